// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2.sv
`default_nettype none
// ============================================================================
// Module      : gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2
// Description : Two-requester round-robin arbiter feeding a registered AOI22.
//               The granted requester's product term (A1&A2 or B1&B2) is
//               inverted and registered onto ZN; with no grant ZN is 1.
// Ports       : CLK          - clock, rising edge
//               RST          - asynchronous active-high reset
//               REQ_A/REQ_B  - access requests
//               A1,A2/B1,B2  - product-term operands of requesters A/B
//               GNT_A/GNT_B  - registered grants (one-hot or both low)
//               ZN           - registered AOI22 result of the granted term
//               BUSY         - high while either grant is high
//               VDD/VSS      - power pins, only with USE_POWER_PINS
// Options     : GF180MCU_FD_SC_MCU9T5V0__AOI22_ARB2_TIMEOUT_EN compiles in
//               an 8-bit hold counter limiting a grant to TMO_CYC cycles
//               while the other side is waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2 #(
    parameter int TMO_CYC = 15
) (
`ifdef USE_POWER_PINS
    inout  wire  VDD,
    inout  wire  VSS,
`endif
    input  logic CLK,
    input  logic RST,
    input  logic REQ_A,
    input  logic REQ_B,
    input  logic A1,
    input  logic A2,
    input  logic B1,
    input  logic B2,
    output logic GNT_A,
    output logic GNT_B,
    output logic ZN,
    output logic BUSY
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   r_last_b;   // 1: B was granted most recently, 0: A
    logic   r_zn;
    logic   w_req_a;
    logic   w_req_b;
    logic   w_tmo;      // owner has used up its hold budget

    // Only a clean 1 counts as a request; X/Z reads as idle.
    assign w_req_a = (REQ_A === 1'b1);
    assign w_req_b = (REQ_B === 1'b1);

    // Out-of-range limits leave an empty, named marker block in elaboration.
    if (TMO_CYC < 1 || TMO_CYC > 255) begin : g_tmo_out_of_range
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__AOI22_ARB2_TIMEOUT_EN
    localparam logic [7:0] C_TMO = 8'(TMO_CYC);
    logic [7:0] r_cnt;

    assign w_tmo = (r_cnt == C_TMO);

    // Cleared whenever ownership changes, counts while owned, saturates.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt <= 8'd0;
        end else if (w_next != r_state) begin
            r_cnt <= 8'd0;
        end else if (r_state != IDLE && !w_tmo) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_req_a && w_req_b) begin
                    w_next = r_last_b ? OWN_A : OWN_B;
                end else if (w_req_a) begin
                    w_next = OWN_A;
                end else if (w_req_b) begin
                    w_next = OWN_B;
                end
            end
            OWN_A: begin
                // Release or timeout hands straight to a waiting B, no bubble.
                if (w_req_a && !(w_tmo && w_req_b)) begin
                    w_next = OWN_A;
                end else if (w_req_b) begin
                    w_next = OWN_B;
                end else begin
                    w_next = IDLE;
                end
            end
            OWN_B: begin
                if (w_req_b && !(w_tmo && w_req_a)) begin
                    w_next = OWN_B;
                end else if (w_req_a) begin
                    w_next = OWN_A;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_last_b <= 1'b1;   // A wins the first tie after reset
        end else begin
            r_state <= w_next;
            if (w_next == OWN_A) begin
                r_last_b <= 1'b0;
            end else if (w_next == OWN_B) begin
                r_last_b <= 1'b1;
            end
        end
    end

    // Uses the grant in force before the edge, so ZN trails the grant by one.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_zn <= 1'b1;
        end else begin
            r_zn <= ~(((r_state == OWN_A) & A1 & A2) |
                      ((r_state == OWN_B) & B1 & B2));
        end
    end

    assign GNT_A = (r_state == OWN_A);
    assign GNT_B = (r_state == OWN_B);
    assign BUSY  = GNT_A | GNT_B;
    assign ZN    = r_zn;

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2
// Description : Directed, table-driven bench for the AOI22 arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2;

    logic CLK, RST, REQ_A, REQ_B, A1, A2, B1, B2;
    logic GNT_A, GNT_B, ZN, BUSY;
`ifdef USE_POWER_PINS
    wire VDD, VSS;
`endif

    int total = 0;
    int bad   = 0;

    gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2 #(.TMO_CYC(4)) dut (
`ifdef USE_POWER_PINS
        .VDD   (VDD),
        .VSS   (VSS),
`endif
        .CLK   (CLK),
        .RST   (RST),
        .REQ_A (REQ_A),
        .REQ_B (REQ_B),
        .A1    (A1),
        .A2    (A2),
        .B1    (B1),
        .B2    (B2),
        .GNT_A (GNT_A),
        .GNT_B (GNT_B),
        .ZN    (ZN),
        .BUSY  (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic ra, rb, a1, a2, b1, b2;
        logic ga, gb, zn;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    // Grants must never overlap.
    always @(negedge CLK) begin
        if (!RST) begin
            total++;
            if (GNT_A && GNT_B) begin
                bad++;
                $display("FAIL overlap: got gnt_a=%0b gnt_b=%0b want not both", GNT_A, GNT_B);
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        #2;
        RST = 1'b0;
    endtask

    initial begin
        int n;
        // ra rb a1 a2 b1 b2 | ga gb zn
        tbl[0]  = '{0,0,1,1,1,1, 0,0,1};
        tbl[1]  = '{1,1,1,1,1,1, 1,0,1};   // tie after reset -> A
        tbl[2]  = '{1,1,1,1,1,1, 1,0,0};
        tbl[3]  = '{0,1,1,0,1,1, 0,1,1};   // A drops -> B, no idle
        tbl[4]  = '{0,1,1,1,1,1, 0,1,0};
        tbl[5]  = '{0,1,1,1,1,0, 0,1,1};   // B2=0, A ops ignored
        tbl[6]  = '{0,0,1,1,1,1, 0,0,0};
        tbl[7]  = '{0,0,1,1,1,1, 0,0,1};
        tbl[8]  = '{1,1,1,1,1,1, 1,0,1};   // last=B -> A
        tbl[9]  = '{0,0,1,1,1,1, 0,0,0};
        tbl[10] = '{1,1,1,1,1,1, 0,1,1};   // last=A -> B
        tbl[11] = '{1,0,1,1,0,1, 1,0,1};
        tbl[12] = '{0,0,1,1,1,1, 0,0,0};

        RST = 1'b1; REQ_A = 0; REQ_B = 0; A1 = 0; A2 = 0; B1 = 0; B2 = 0;
        #2;
        check("rst gnt_a", GNT_A, 1'b0);
        check("rst gnt_b", GNT_B, 1'b0);
        check("rst busy",  BUSY,  1'b0);
        check("rst zn",    ZN,    1'b1);
        @(negedge CLK);
        RST = 1'b0;

        for (int i = 0; i < 13; i++) begin
            REQ_A = tbl[i].ra; REQ_B = tbl[i].rb;
            A1 = tbl[i].a1; A2 = tbl[i].a2; B1 = tbl[i].b1; B2 = tbl[i].b2;
            @(posedge CLK); #1;
            check($sformatf("v%0d gnt_a", i), GNT_A, tbl[i].ga);
            check($sformatf("v%0d gnt_b", i), GNT_B, tbl[i].gb);
            check($sformatf("v%0d zn", i),    ZN,    tbl[i].zn);
            check($sformatf("v%0d busy", i),  BUSY,  tbl[i].ga | tbl[i].gb);
        end

        // Asynchronous reset in the middle of an A grant (LAST becomes A).
        A1 = 1; A2 = 1; REQ_A = 1; REQ_B = 0;
        @(posedge CLK); #1;
        check("pre-rst gnt_a", GNT_A, 1'b1);
        @(posedge CLK); #3;
        RST = 1'b1;
        #1;
        check("async gnt_a", GNT_A, 1'b0);
        check("async busy",  BUSY,  1'b0);
        check("async zn",    ZN,    1'b1);
        @(negedge CLK);
        RST = 1'b0;
        REQ_A = 1; REQ_B = 1;
        @(posedge CLK); #1;
        check("post-rst tie gnt_a", GNT_A, 1'b1);
        REQ_A = 0;
        @(posedge CLK); #1;
        check("post-rst handoff gnt_b", GNT_B, 1'b1);
        REQ_B = 0;
        @(posedge CLK); #1;

        // Eight tie episodes alternate A,B,A,B...
        do_reset();
        for (int ep = 0; ep < 8; ep++) begin
            REQ_A = 1; REQ_B = 1;
            @(posedge CLK); #1;
            check($sformatf("alt%0d gnt_a", ep), GNT_A, (ep % 2) == 0);
            check($sformatf("alt%0d gnt_b", ep), GNT_B, (ep % 2) == 1);
            REQ_A = 0; REQ_B = 0;
            @(posedge CLK); #1;
        end

        // Owner keeps requesting while B waits.
        do_reset();
        REQ_A = 1; REQ_B = 0;
        @(posedge CLK); #1;
        check("hold gnt_a", GNT_A, 1'b1);
        REQ_B = 1;
        n = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge CLK); #1;
            if (!GNT_A) break;
            n++;
        end
`ifdef GF180MCU_FD_SC_MCU9T5V0__AOI22_ARB2_TIMEOUT_EN
        total++;
        if (n != 5) begin
            bad++;
            $display("FAIL tmo cycles: got %0d want 5", n);
        end
        check("tmo gnt_b", GNT_B, 1'b1);
`else
        total++;
        if (n != 21) begin
            bad++;
            $display("FAIL hold cycles: got %0d want 21", n);
        end
        check("hold still gnt_a", GNT_A, 1'b1);
`endif
        REQ_A = 0; REQ_B = 0;
        @(posedge CLK); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2.md
GF180MCU_FD_SC_MCU9T5V0__AOI22_ARB2 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__aoi22_arb2

Interface
REQ-001 SHALL provide parameter TMO_CYC, default 15, meaning the grant-hold cycle limit (range 1..255) when the timeout feature is compiled in.
REQ-002 SHALL provide port CLK  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL provide port RST  input  1  reset; asynchronous, active-high.
REQ-004 SHALL provide ports REQ_A, REQ_B  input  1 each  access requests from requesters A and B.
REQ-005 SHALL provide ports A1, A2  input  1 each  requester A product-term operands.
REQ-006 SHALL provide ports B1, B2  input  1 each  requester B product-term operands.
REQ-007 SHALL provide ports GNT_A, GNT_B  output  1 each  registered grants; one-hot or both low.
REQ-008 SHALL provide port ZN  output  1  registered AOI22 result of the granted term.
REQ-009 SHALL provide port BUSY  output  1  high while either grant is high.
REQ-010 SHALL provide ports VDD, VSS  inout  1 each, present only when USE_POWER_PINS is defined.

Function
REQ-011 SHALL implement states IDLE, OWN_A, OWN_B; GNT_A = (state==OWN_A), GNT_B = (state==OWN_B), BUSY = GNT_A|GNT_B.
REQ-012 SHALL hold a LAST register (A or B) recording the most recently granted requester.
REQ-013 IDLE: REQ_A only -> OWN_A; REQ_B only -> OWN_B; both -> the requester not equal to LAST; neither -> stay IDLE.
REQ-014 OWN_A: REQ_A high -> stay; REQ_A low and REQ_B high -> OWN_B in one cycle (no IDLE bubble); both low -> IDLE. OWN_B is symmetric.
REQ-015 SHALL update LAST on every entry into OWN_A or OWN_B.
REQ-016 Grant latency: GNT_x high on the first rising edge at which REQ_x is sampled high and wins arbitration; never combinational from REQ_x.
REQ-017 ZN SHALL be registered each cycle as NOT((GNT_A & A1 & A2) | (GNT_B & B1 & B2)), using pre-edge grant values; ZN therefore lags the grant by one cycle.
REQ-018 With no grant active, ZN SHALL be registered as 1.
REQ-019 Simultaneous release of the owner and a request from the other side SHALL hand off within the same edge (REQ-014); simultaneous requests from IDLE SHALL resolve per LAST.
REQ-020 GNT_A and GNT_B SHALL never be high in the same cycle.
REQ-021 X/Z on REQ_x SHALL be treated as not requesting.

Reset
REQ-022 RST high SHALL asynchronously force state IDLE, GNT_A=0, GNT_B=0, BUSY=0, ZN=1, LAST=B (A wins the first tie), timeout counter 0.
REQ-023 RST asserted mid-grant SHALL drop the grant immediately without waiting for CLK; the first arbitration after RST deassertion follows REQ-013.

Configuration
REQ-024 Macro GF180MCU_FD_SC_MCU9T5V0__AOI22_ARB2_TIMEOUT_EN SHALL compile in an 8-bit hold counter.
REQ-025 With macro: counter clears on entry to OWN_x, increments each cycle in OWN_x, saturates at TMO_CYC; at TMO_CYC with the other requester high, SHALL force switch to the other owner on the next edge even if the owner still requests; with the other low, ownership persists.
REQ-026 Without macro: no counter logic; ownership ends only by owner release (REQ-014); TMO_CYC is unused.

Verification
REQ-027 RST pulse mid-OWN_A -> GNT_A falls before next CLK edge; ZN=1, BUSY=0.
REQ-028 From IDLE after reset, REQ_A=REQ_B=1 at same edge -> GNT_A=1 next cycle; drop REQ_A -> GNT_B=1 next cycle, no IDLE cycle.
REQ-029 OWN_B, B1=B2=1, A1=A2=1 -> ZN=0 one cycle after GNT_B; B2=0 -> ZN=1 next cycle; A inputs ignored.
REQ-030 Alternating simultaneous requests over 8 grant episodes -> grants alternate A,B,A,B...; GNT_A&GNT_B never observed.
REQ-031 TIMEOUT_EN, TMO_CYC=4, REQ_A held, REQ_B raised -> GNT_B after GNT_A high 5 cycles; without macro GNT_A stays high indefinitely.
